find_max_arbiter: RTL and testbench
===================================

// Module: find_max_arbiter
// PURPOSE
//  Round-robin arbiter sharing one find_max engine (comparator tree + data FIFOs) among NUM_REQ requesters.
//  Grants one requester beat per engine transfer and records the requester index in an in-order tag FIFO.
//  Routes each engine result (data_out beat + max_num) back to the requester that issued it.
//  Sits between the per-head quantization front-ends and a single shared find_max instance.
// PARAMETERS
//  NUM_REQ    2   number of requesters (>=2)
//  IN_WIDTH   16  element width (FP16 bit pattern), also max_num width
//  IN_SIZE    4   elements per beat (engine IN_SIZE*IN_PARALLELISM)
//  TAG_DEPTH  4   max in-flight beats; tag FIFO depth (>= engine latency + 1 for full throughput)
//  TAG_W      $clog2(NUM_REQ) (localparam) requester-index width
// PORTS
//  clk                input   1                     clock
//  rst                input   1                     synchronous active-high reset
//  req_data_in        input   IN_WIDTH x NUM_REQ*IN_SIZE  requester r owns elements [r*IN_SIZE +: IN_SIZE]
//  req_data_in_valid  input   NUM_REQ               per-requester valid
//  req_data_in_ready  output  NUM_REQ               per-requester ready (only granted bit can be 1)
//  eng_data_in        output  IN_WIDTH x IN_SIZE     beat to engine
//  eng_data_in_valid  output  1                     to engine
//  eng_data_in_ready  input   1                     from engine
//  eng_data_out       input   IN_WIDTH x IN_SIZE     buffered beat from engine
//  eng_max_num        input   IN_WIDTH              engine max, synchronous with eng_data_out
//  eng_data_out_valid input   1                     from engine
//  eng_data_out_ready output  1                     to engine
//  rsp_data_out       output  IN_WIDTH x IN_SIZE     shared response bus (= eng_data_out)
//  rsp_max_num        output  IN_WIDTH              shared response max (= eng_max_num)
//  rsp_valid          output  NUM_REQ               one-hot on head tag, else 0
//  rsp_ready          input   NUM_REQ               per-requester ready
//  in_flight          output  $clog2(TAG_DEPTH+1)   tag FIFO occupancy
//  tag_underflow      output  1                     sticky error: engine result with no tag
// BEHAVIOUR
//  Reset: rr_ptr=0, tag FIFO empty, in_flight=0, tag_underflow=0; hence all valid/ready outputs 0.
//  Grant (combinational): g = first r with req_data_in_valid[r], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//  can_issue = any valid && !tag_full. eng_data_in_valid=can_issue; eng_data_in = slice of g (zeros if none).
//  req_data_in_ready[r] = (r==g) && can_issue && eng_data_in_ready; no valid->ready loop on other requesters.
//  Issue = eng_data_in_valid && eng_data_in_ready: push g into tag FIFO; rr_ptr <= (g+1) mod NUM_REQ.
//  No issue -> rr_ptr holds; unserved requester keeps its priority until granted.
//  Full: push blocked when tag_full even if a pop occurs same cycle (no bypass; one-cycle bubble accepted).
//  Response: head tag h valid only if !tag_empty. rsp_valid[h] = eng_data_out_valid; others 0.
//  eng_data_out_ready = !tag_empty && rsp_ready[h]. Pop = eng_data_out_valid && eng_data_out_ready.
//  Simultaneous push+pop (not full): occupancy unchanged, both pointers advance; pointers wrap at TAG_DEPTH.
//  Empty + eng_data_out_valid: eng_data_out_ready=0, rsp_valid=0, tag_underflow<=1 (cleared only by rst).
//  Results strictly in issue order; latency issue->rsp = engine latency; arbiter adds zero cycles.
//  Reset mid-operation: tags discarded; engine shares rst so nothing remains in flight.
//  Requester protocol: valid/data held stable until ready; arbiter never drops/reorders beats.
// TESTING
//  T1 single: req0 only, 3 beats max-abs {1,-5,3,2}=5 -> 3 rsp on rsp_valid[0], max_num=5 each, in order.
//  T2 fairness: both valid continuously, 8 beats -> grants alternate 0,1,0,1..., each rsp to issuer.
//  T3 full: hold rsp_ready=0, 6 offers -> exactly TAG_DEPTH issues, in_flight=4, eng_data_in_valid=0 after.
//  T4 backpressure: rsp_ready[1]=0 on head tag 1 -> eng_data_out_ready=0, req0 results wait behind it.
//  T5 reset: rst with in_flight=3 -> next cycle in_flight=0, rr_ptr=0, all rsp_valid=0.
//  T6 error: force eng_data_out_valid with tag FIFO empty -> tag_underflow=1, stays 1 until rst.

Source files
------------

// File: rtl/find_max_arbiter.sv
// -----------------------------------------------------------------------------
// find_max_arbiter
//
// Shares one find_max engine (comparator tree + data FIFOs) among NUM_REQ
// requesters. Each cycle a round-robin grant selects at most one requester
// beat and forwards it to the engine. The index of the requester that issued
// the beat is stored in an in-order tag FIFO. The engine returns results in
// issue order. The tag at the FIFO head therefore identifies the requester
// that owns the current engine result. The arbiter routes that result back
// to its requester without adding any cycles of latency.
//
// Parameters
//   NUM_REQ    number of requesters (>= 2)
//   IN_WIDTH   element width (FP16 bit pattern); also the width of max_num
//   IN_SIZE    elements per beat
//   TAG_DEPTH  maximum number of beats in flight (tag FIFO depth)
//
// Ports
//   clk                 clock
//   rst                 synchronous, active-high reset
//   req_data_in         requester r owns bits [r*IN_SIZE*IN_WIDTH +: IN_SIZE*IN_WIDTH]
//   req_data_in_valid   per-requester beat valid
//   req_data_in_ready   per-requester ready; only the granted bit can be 1
//   eng_data_in         beat forwarded to the engine
//   eng_data_in_valid   beat valid towards the engine
//   eng_data_in_ready   engine can accept a beat
//   eng_data_out        buffered beat returned by the engine
//   eng_max_num         engine max, aligned with eng_data_out
//   eng_data_out_valid  engine result valid
//   eng_data_out_ready  result accepted by the owning requester
//   rsp_data_out        shared response bus (copy of eng_data_out)
//   rsp_max_num         shared response max (copy of eng_max_num)
//   rsp_valid           one-hot on the head-tag requester, otherwise 0
//   rsp_ready           per-requester response ready
//   in_flight           tag FIFO occupancy
//   tag_underflow       sticky error: engine produced a result with no tag
// -----------------------------------------------------------------------------
module find_max_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int IN_WIDTH  = 16,
    parameter int IN_SIZE   = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    // requester side
    input  logic [NUM_REQ*IN_SIZE*IN_WIDTH-1:0]   req_data_in,
    input  logic [NUM_REQ-1:0]                    req_data_in_valid,
    output logic [NUM_REQ-1:0]                    req_data_in_ready,
    // engine input side
    output logic [IN_SIZE*IN_WIDTH-1:0]           eng_data_in,
    output logic                                  eng_data_in_valid,
    input  logic                                  eng_data_in_ready,
    // engine output side
    input  logic [IN_SIZE*IN_WIDTH-1:0]           eng_data_out,
    input  logic [IN_WIDTH-1:0]                   eng_max_num,
    input  logic                                  eng_data_out_valid,
    output logic                                  eng_data_out_ready,
    // response side
    output logic [IN_SIZE*IN_WIDTH-1:0]           rsp_data_out,
    output logic [IN_WIDTH-1:0]                   rsp_max_num,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    input  logic [NUM_REQ-1:0]                    rsp_ready,
    // status
    output logic [$clog2(TAG_DEPTH+1)-1:0]        in_flight,
    output logic                                  tag_underflow
);

    localparam int TAG_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = IN_SIZE * IN_WIDTH;
    localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W  = $clog2(TAG_DEPTH + 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [TAG_W-1:0]  r_rr_ptr;                 // highest-priority requester
    logic [TAG_W-1:0]  r_tag_mem [TAG_DEPTH];    // requester index per in-flight beat
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_tag_underflow;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic              w_tag_full;
    logic              w_tag_empty;
    logic              w_any_valid;
    logic [TAG_W-1:0]  w_grant;
    logic [TAG_W:0]    w_sum;
    logic [TAG_W-1:0]  w_idx;
    logic              w_can_issue;
    logic              w_push;
    logic              w_pop;
    logic [TAG_W-1:0]  w_head;
    logic [TAG_W-1:0]  w_next_rr;

    // Pointer increment with an explicit wrap, so TAG_DEPTH does not need to
    // be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_tag_full  = (r_count == CNT_W'(TAG_DEPTH));
    assign w_tag_empty = (r_count == '0);

    // -------------------------------------------------------------------------
    // Round-robin grant: scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and take the
    // first valid requester. The scan index is kept TAG_W+1 bits wide so the
    // sum cannot overflow before the modulo correction.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any conditional code, so
        // no path leaves a value unassigned and no latch is inferred.
        w_any_valid = 1'b0;
        w_grant     = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (TAG_W+1)'(i);
            if (w_sum >= (TAG_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (TAG_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[TAG_W-1:0];
            if (!w_any_valid && req_data_in_valid[w_idx]) begin
                w_any_valid = 1'b1;
                w_grant     = w_idx;
            end
        end
    end

    // The tag FIFO is never bypassed: a full FIFO blocks issue even if a tag
    // is popped in the same cycle. This costs a one-cycle bubble but keeps the
    // full flag purely registered.
    assign w_can_issue       = w_any_valid && !w_tag_full;
    assign eng_data_in_valid = w_can_issue;
    assign w_push            = w_can_issue && eng_data_in_ready;

    // Slice of the granted requester; zeros when nobody is requesting.
    always_comb begin
        eng_data_in = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_any_valid && (w_grant == TAG_W'(r))) begin
                eng_data_in = req_data_in[r*BEAT_W +: BEAT_W];
            end
        end
    end

    // Only the granted requester sees ready. Its ready does not depend on the
    // valid bits of the other requesters beyond the grant decision itself.
    always_comb begin
        req_data_in_ready = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_data_in_ready[r] = (w_grant == TAG_W'(r)) && w_can_issue && eng_data_in_ready;
        end
    end

    // The requester after the one just served becomes the highest priority.
    assign w_next_rr = (w_grant == TAG_W'(NUM_REQ - 1)) ? '0 : w_grant + TAG_W'(1);

    // -------------------------------------------------------------------------
    // Response routing
    // -------------------------------------------------------------------------
    assign w_head = r_tag_mem[r_rd_ptr];

    // The head tag is meaningful only while the FIFO holds something. A result
    // arriving with an empty FIFO is not routed anywhere and is flagged.
    always_comb begin
        rsp_valid = '0;
        if (!w_tag_empty) begin
            rsp_valid[w_head] = eng_data_out_valid;
        end
    end

    assign eng_data_out_ready = !w_tag_empty && rsp_ready[w_head];
    assign w_pop              = eng_data_out_valid && eng_data_out_ready;

    assign rsp_data_out = eng_data_out;
    assign rsp_max_num  = eng_max_num;

    // -------------------------------------------------------------------------
    // Control registers: round-robin pointer, FIFO pointers, occupancy and
    // the sticky underflow flag.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_rr_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_tag_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
                r_rr_ptr <= w_next_rr;
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (eng_data_out_valid && w_tag_empty) begin
                r_tag_underflow <= 1'b1;
            end
        end
    end

    // Tag storage.
    // NOTE: the storage array has no reset; the pointers and the occupancy
    // count decide which entries are live, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_grant;
        end
    end

    assign in_flight     = r_count;
    assign tag_underflow = r_tag_underflow;

endmodule

// File: tb/tb_find_max_arbiter.sv
// -----------------------------------------------------------------------------
// tb_find_max_arbiter
//
// Directed bench for find_max_arbiter. A behavioural engine model (two-cycle
// latency, max-abs over the FP16 elements) sits behind the arbiter. Requester
// drivers push the expected response into a scoreboard queue when a beat is
// accepted. A separate monitor pops and compares each response handshake.
// Expected data and max values are hand-computed FP16 constants.
// -----------------------------------------------------------------------------
module tb_find_max_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int IN_WIDTH  = 16;
    localparam int IN_SIZE   = 4;
    localparam int TAG_DEPTH = 4;
    localparam int BEAT_W    = IN_WIDTH * IN_SIZE;
    localparam int CNT_W     = $clog2(TAG_DEPTH + 1);

    // Beats (element 0 in the low 16 bits) and their hand-computed max-abs.
    // 1.0=3C00 -5=C500 3=4200 2=4000 -> 5=4500
    localparam logic [BEAT_W-1:0] V_A = {16'h4000, 16'h4200, 16'hC500, 16'h3C00};
    localparam logic [BEAT_W-1:0] V_B = {16'hC500, 16'h3C00, 16'h4000, 16'h4200};
    localparam logic [BEAT_W-1:0] V_C = {16'h3C00, 16'h4000, 16'hC500, 16'h4200};
    // 1.0 -9=C880 4=4400 2 -> 9=4880
    localparam logic [BEAT_W-1:0] V_D = {16'h3C00, 16'hC880, 16'h4400, 16'h4000};
    // 4 0.5=3800 -6=C600 2.5=4100 -> 6=4600
    localparam logic [BEAT_W-1:0] V_E = {16'h4400, 16'h3800, 16'hC600, 16'h4100};
    // -9 1.0 3 2 -> 9=4880
    localparam logic [BEAT_W-1:0] V_F = {16'hC880, 16'h3C00, 16'h4200, 16'h4000};
    localparam logic [IN_WIDTH-1:0] M5 = 16'h4500;
    localparam logic [IN_WIDTH-1:0] M6 = 16'h4600;
    localparam logic [IN_WIDTH-1:0] M9 = 16'h4880;

    logic                              clk = 1'b0;
    logic                              rst = 1'b1;
    logic [NUM_REQ*BEAT_W-1:0]         req_data_in = '0;
    logic [NUM_REQ-1:0]                req_data_in_valid = '0;
    logic [NUM_REQ-1:0]                req_data_in_ready;
    logic [BEAT_W-1:0]                 eng_data_in;
    logic                              eng_data_in_valid;
    logic                              eng_data_in_ready = 1'b1;
    logic [BEAT_W-1:0]                 eng_data_out;
    logic [IN_WIDTH-1:0]               eng_max_num;
    logic                              eng_data_out_valid;
    logic                              eng_data_out_ready;
    logic [BEAT_W-1:0]                 rsp_data_out;
    logic [IN_WIDTH-1:0]               rsp_max_num;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [NUM_REQ-1:0]                rsp_ready = '1;
    logic [CNT_W-1:0]                  in_flight;
    logic                              tag_underflow;

    find_max_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IN_WIDTH (IN_WIDTH),
        .IN_SIZE  (IN_SIZE),
        .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_data_in       (req_data_in),
        .req_data_in_valid (req_data_in_valid),
        .req_data_in_ready (req_data_in_ready),
        .eng_data_in       (eng_data_in),
        .eng_data_in_valid (eng_data_in_valid),
        .eng_data_in_ready (eng_data_in_ready),
        .eng_data_out      (eng_data_out),
        .eng_max_num       (eng_max_num),
        .eng_data_out_valid(eng_data_out_valid),
        .eng_data_out_ready(eng_data_out_ready),
        .rsp_data_out      (rsp_data_out),
        .rsp_max_num       (rsp_max_num),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .in_flight         (in_flight),
        .tag_underflow     (tag_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BEAT_W-1:0]   data;
        logic [IN_WIDTH-1:0] mx;
    } beat_t;

    typedef struct {
        int                  req;
        logic [BEAT_W-1:0]   data;
        logic [IN_WIDTH-1:0] mx;
    } exp_t;

    typedef struct {
        logic [BEAT_W-1:0] data;
        int                rdy;
    } eng_t;

    beat_t  req_q [NUM_REQ][$];
    exp_t   exp_q [$];
    eng_t   eng_q [$];
    int     issue_log [$];
    int     rsp_cnt [NUM_REQ];
    int     cyc    = 0;
    int     checks = 0;
    int     errors = 0;

    logic                force_ov = 1'b0;
    logic                eng_ov_q = 1'b0;
    logic [BEAT_W-1:0]   eng_do_q = '0;
    logic [IN_WIDTH-1:0] eng_mx_q = '0;

    assign eng_data_out_valid = eng_ov_q | force_ov;
    assign eng_data_out       = eng_do_q;
    assign eng_max_num        = eng_mx_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine stand-in: max-abs of the FP16 elements (sign bit cleared).
    function automatic logic [IN_WIDTH-1:0] max_abs(input logic [BEAT_W-1:0] d);
        logic [IN_WIDTH-1:0] m;
        logic [IN_WIDTH-1:0] e;
        m = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            e = d[i*IN_WIDTH +: IN_WIDTH];
            e[IN_WIDTH-1] = 1'b0;
            if (e > m) m = e;
        end
        return m;
    endfunction

    // Engine model: handshakes observed on the falling edge, outputs driven
    // just after the rising edge; a result appears two edges after acceptance.
    initial begin : engine
        eng_t ent;
        forever begin
            @(negedge clk);
            if (rst) begin
                eng_q.delete();
            end else begin
                if (eng_ov_q && eng_data_out_ready && eng_q.size() > 0) begin
                    void'(eng_q.pop_front());
                end
                if (eng_data_in_valid && eng_data_in_ready) begin
                    ent.data = eng_data_in;
                    ent.rdy  = cyc + 2;
                    eng_q.push_back(ent);
                end
            end
            @(posedge clk);
            #1;
            if (eng_q.size() > 0 && eng_q[0].rdy <= cyc) begin
                eng_ov_q = 1'b1;
                eng_do_q = eng_q[0].data;
                eng_mx_q = max_abs(eng_q[0].data);
            end else begin
                eng_ov_q = 1'b0;
                eng_do_q = '0;
                eng_mx_q = '0;
            end
        end
    end

    // Requester drivers: hold valid/data until accepted; on acceptance the
    // expected response is queued for the monitor.
    initial begin : drivers
        beat_t b;
        exp_t  e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (req_data_in_valid[r] && req_data_in_ready[r] && req_q[r].size() > 0) begin
                        b      = req_q[r].pop_front();
                        e.req  = r;
                        e.data = b.data;
                        e.mx   = b.mx;
                        exp_q.push_back(e);
                        issue_log.push_back(r);
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (req_q[r].size() > 0) begin
                    req_data_in_valid[r]              = 1'b1;
                    req_data_in[r*BEAT_W +: BEAT_W] = req_q[r][0].data;
                end else begin
                    req_data_in_valid[r]              = 1'b0;
                    req_data_in[r*BEAT_W +: BEAT_W] = '0;
                end
            end
        end
    end

    // Response monitor: every response handshake must match the oldest
    // outstanding issue, including the requester it is routed to.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rsp_valid != '0) begin
                    check("rsp_onehot", 64'($countones(rsp_valid)), 64'(1));
                end
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (rsp_valid[r] && rsp_ready[r]) begin
                        rsp_cnt[r]++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rsp_unexpected: response on requester %0d with nothing outstanding", r);
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp_req", 64'(r), 64'(e.req));
                            check("rsp_data", 64'(rsp_data_out), 64'(e.data));
                            check("rsp_max", 64'(rsp_max_num), 64'(e.mx));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Move to 2 time units after a rising edge, after drivers have updated.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load(input int r, input logic [BEAT_W-1:0] d, input logic [IN_WIDTH-1:0] m);
        beat_t b;
        b.data = d;
        b.mx   = m;
        req_q[r].push_back(b);
    endtask

    task automatic clear_log();
        issue_log.delete();
        for (int r = 0; r < NUM_REQ; r++) rsp_cnt[r] = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        exp_q.delete();
        for (int r = 0; r < NUM_REQ; r++) req_q[r].delete();
        clear_log();
        tick(2);
        rst = 1'b0;
    endtask

    function automatic int pending();
        int n;
        n = exp_q.size();
        for (int r = 0; r < NUM_REQ; r++) n += req_q[r].size();
        return n;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (pending() != 0 || in_flight != '0 || req_data_in_valid != '0) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: still busy after %0d cycles", budget);
                break;
            end
        end
        tick(1);
    endtask

    // Issue order check: bit i of pat is the requester expected at issue i.
    task automatic check_order(input string name, input logic [31:0] pat, input int n);
        check({name, "_len"}, 64'(issue_log.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < issue_log.size()) begin
                check(name, 64'(issue_log[i]), 64'(pat[i]));
            end
        end
    endtask

    initial begin : main
        tick(1);
        apply_reset();

        // Reset state
        @(negedge clk);
        check("rst_in_flight", 64'(in_flight), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_req_ready", 64'(req_data_in_ready), 64'(0));
        check("rst_eng_in_valid", 64'(eng_data_in_valid), 64'(0));
        check("rst_eng_out_ready", 64'(eng_data_out_ready), 64'(0));
        check("rst_underflow", 64'(tag_underflow), 64'(0));
        tick(1);

        // T1: single requester, three beats, all max 5
        clear_log();
        load(0, V_A, M5);
        load(0, V_B, M5);
        load(0, V_C, M5);
        wait_idle(100);
        check_order("t1_grant", 32'h0, 3);
        check("t1_rsp0", 64'(rsp_cnt[0]), 64'(3));
        check("t1_rsp1", 64'(rsp_cnt[1]), 64'(0));

        // T2: both requesters continuously valid; rr_ptr is 1 after T1
        clear_log();
        load(0, V_A, M5); load(0, V_D, M9); load(0, V_B, M5); load(0, V_C, M5);
        load(1, V_E, M6); load(1, V_F, M9); load(1, V_E, M6); load(1, V_F, M9);
        wait_idle(200);
        check_order("t2_grant", 32'h55, 8);
        check("t2_rsp0", 64'(rsp_cnt[0]), 64'(4));
        check("t2_rsp1", 64'(rsp_cnt[1]), 64'(4));

        // T3: responses blocked, six offers -> tag FIFO fills at TAG_DEPTH
        clear_log();
        rsp_ready = '0;
        for (int i = 0; i < 6; i++) load(0, (i % 2 == 0) ? V_A : V_D, (i % 2 == 0) ? M5 : M9);
        tick(12);
        @(negedge clk);
        check("t3_issued", 64'(issue_log.size()), 64'(TAG_DEPTH));
        check("t3_in_flight", 64'(in_flight), 64'(TAG_DEPTH));
        check("t3_eng_in_valid", 64'(eng_data_in_valid), 64'(0));
        check("t3_req_ready", 64'(req_data_in_ready), 64'(0));
        tick(1);
        rsp_ready = '1;
        wait_idle(200);
        check_order("t3_grant", 32'h0, 6);

        // T4: head tag belongs to requester 1, which is not ready
        clear_log();
        rsp_ready = 2'b01;
        load(1, V_E, M6);
        load(0, V_A, M5);
        load(0, V_D, M9);
        tick(10);
        @(negedge clk);
        check("t4_in_flight", 64'(in_flight), 64'(3));
        check("t4_eng_out_valid", 64'(eng_data_out_valid), 64'(1));
        check("t4_eng_out_ready", 64'(eng_data_out_ready), 64'(0));
        check("t4_rsp_valid", 64'(rsp_valid), 64'(2'b10));
        tick(1);
        rsp_ready = '1;
        wait_idle(200);
        check_order("t4_grant", 32'h1, 3);

        // T5: reset with three beats in flight; rr_ptr is 1 before reset
        clear_log();
        rsp_ready = '0;
        load(0, V_B, M5);
        load(0, V_C, M5);
        load(0, V_A, M5);
        tick(10);
        @(negedge clk);
        check("t5_in_flight_pre", 64'(in_flight), 64'(3));
        tick(1);
        apply_reset();
        @(negedge clk);
        check("t5_in_flight", 64'(in_flight), 64'(0));
        check("t5_rsp_valid", 64'(rsp_valid), 64'(0));
        check("t5_eng_out_ready", 64'(eng_data_out_ready), 64'(0));
        tick(1);
        rsp_ready = '1;
        load(0, V_B, M5);
        load(1, V_E, M6);
        @(posedge clk);
        @(negedge clk);
        check("t5_rr_reset_grant", 64'(req_data_in_ready), 64'(2'b01));
        wait_idle(100);
        check_order("t5_grant", 32'h2, 2);

        // T6: engine result with an empty tag FIFO
        check("t6_underflow_pre", 64'(tag_underflow), 64'(0));
        force_ov = 1'b1;
        @(negedge clk);
        check("t6_eng_out_ready", 64'(eng_data_out_ready), 64'(0));
        check("t6_rsp_valid", 64'(rsp_valid), 64'(0));
        tick(1);
        force_ov = 1'b0;
        @(negedge clk);
        check("t6_underflow_set", 64'(tag_underflow), 64'(1));
        tick(1);
        load(1, V_F, M9);
        wait_idle(100);
        @(negedge clk);
        check("t6_underflow_sticky", 64'(tag_underflow), 64'(1));
        tick(1);
        apply_reset();
        @(negedge clk);
        check("t6_underflow_clr", 64'(tag_underflow), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
